alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
- Pipeline register stage directly downstream of the ALU. It captures each ALU result, zero flag and writeback tag, and presents them to the register-file writeback port through a valid/ready handshake.
- A 2-entry skid buffer absorbs writeback stalls without combinational ready paths back into execute.
- The stage also holds the architectural N/Z condition flags, updated when a flag-setting op retires.

Parameters:
- DATA_W, 32, width of ALU result / writeback data
- ADDR_W, 4, register-file address width (r0-r15)

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- in_valid  input  1  ALU output carries a valid op
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready
- in_result  input  DATA_W  ALU result
- in_zero  input  1  ALU zero_flag
- in_rd  input  ADDR_W  destination register
- in_wen  input  1  op writes in_rd
- in_setf  input  1  op updates N/Z flags
- flush  input  1  synchronous pipeline flush (branch/exception)
- out_valid  output  1  head entry valid
- out_ready  input  1  writeback accepts head entry
- out_data  output  DATA_W  head entry result
- out_rd  output  ADDR_W  head entry destination
- out_wen  output  1  head entry write enable
- flag_n  output  1  committed negative flag
- flag_z  output  1  committed zero flag

Behaviour:
- Reset (async assert, sync release): both entries invalid, out_valid=0, in_ready=1, out_data=0, out_rd=0, out_wen=0, flag_n=0, flag_z=0.
- Storage is two entries, main (head, drives out_*) and skid. Each entry holds result, zero, rd, wen, setf, valid.
- Input accept = in_valid & in_ready. Output retire = out_valid & out_ready.
- Latency: an op accepted in cycle T appears on out_* in T+1 if main is empty or retiring in T. Otherwise it waits in skid.
- in_ready = !skid.valid, driven from a flop.
- Occupancy transitions per cycle:
  - empty + accept -> main.
  - main only + accept + no retire -> new op to skid; in_ready drops next cycle.
  - main only + accept + retire -> new op replaces main.
  - main+skid + retire -> skid moves to main; in_ready=1 next cycle. No accept is possible while full.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- Flags: on retire of an entry with setf=1, flag_z <= entry.zero and flag_n <= entry.result[DATA_W-1] in the same edge. Entries with setf=0 leave the flags unchanged. Flags never update on accept.
- out_data/out_rd/out_wen hold their values while out_valid=1 & out_ready=0. They hold their last value when out_valid=0.
- flush=1 (synchronous) invalidates both entries and discards any same-cycle accept. in_ready=1 next cycle. Flags are unchanged, except that a retire in the same cycle as flush still commits, because writeback has already consumed it.
- Reset mid-operation: all entries are discarded immediately and outputs return to reset values asynchronously.
- out_wen=0 with out_valid=1 is legal (compare-type ops). It still retires and can still set flags.
- The stage performs no arithmetic on data. in_result passes through bit-exact.

Decomposition:
- Shared package (alu_pkg): DATA_W/ADDR_W defaults, the ALU control opcode constants (AND 0000, OR 0001, ADD 0010, SUB 0011, SLT 0100, XOR 0110), and the entry struct {result, zero, rd, wen, setf}.
- One sub-module is natural: alu_skid_buffer, a generic 2-entry valid/ready skid buffer parameterised on payload width.
- alu_result_stage instantiates alu_skid_buffer and adds the flush and N/Z flag-commit logic.

Test Plan:
- Streaming:
  - Stimulus: out_ready=1; accept 0x0000_0005 rd=3 wen=1 setf=1 zero=0, then 0x8000_0000 rd=4 setf=1.
  - Response: out_* one cycle after each accept. After the second retire, flag_n=1 and flag_z=0.
- Backpressure:
  - Stimulus: out_ready=0; accept A=0x11 then B=0x22.
  - Response: in_ready=0 the cycle after B; out_data holds 0x11. After raising out_ready, 0x11 and then 0x22 retire in consecutive cycles, and in_ready returns to 1.
- Flag gating:
  - Stimulus: retire result=0 zero=1 setf=0, then result=0 zero=1 setf=1.
  - Response: flag_z stays 0 after the first retire and becomes 1 after the second.
- Flush:
  - Stimulus: stage full (0xAA, 0xBB), out_ready=0; assert flush together with in_valid for 0xCC.
  - Response: next cycle out_valid=0 and in_ready=1, and 0xCC never appears. Flags are unchanged.
- Async reset mid-stall:
  - Stimulus: stage full with flag_z=1; drop rst_n between clock edges.
  - Response: out_valid, flag_n and flag_z go to 0 immediately and in_ready=1. After release, a fresh accept of 0x7 retires normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, control opcodes and the result-stage entry layout.
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic [ADDR_W-1:0] rd;
    logic              wen;
    logic              setf;
  } entry_t;
endpackage

// File: rtl/alu_skid_buffer.sv
// alu_skid_buffer: 2-entry valid/ready skid buffer; in_ready comes straight from a flop.
module alu_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         main_v, skid_v;
  logic [W-1:0] main_d, skid_d;
  logic         accept, retire;
  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign accept    = in_valid & ~skid_v;
  assign retire    = main_v & out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (clear) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (retire) begin
        main_d <= skid_d;
        skid_v <= 1'b0;
      end
    end else if (accept) begin
      // a retiring or empty head takes the new op directly, otherwise it parks in skid
      if (!main_v || retire) begin
        main_d <= in_data;
        main_v <= 1'b1;
      end else begin
        skid_d <= in_data;
        skid_v <= 1'b1;
      end
    end else if (retire) begin
      main_v <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: ALU output register stage with skid buffering, flush and N/Z flag commit.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int ADDR_W = alu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wen,
  input  logic              in_setf,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wen,
  output logic              flag_n,
  output logic              flag_z
);
  localparam int PW = DATA_W + ADDR_W + 3;
  logic [PW-1:0] in_p, head;
  logic          head_zero, head_setf;
  assign in_p = {in_result, in_zero, in_rd, in_wen, in_setf};
  alu_skid_buffer #(.W(PW)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_p),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head)
  );
  assign out_data  = head[PW-1 -: DATA_W];
  assign head_zero = head[ADDR_W+2];
  assign out_rd    = head[ADDR_W+1:2];
  assign out_wen   = head[1];
  assign head_setf = head[0];
  // a retire coinciding with flush still commits: writeback already consumed it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
    end else if (out_valid && out_ready && head_setf) begin
      flag_n <= out_data[DATA_W-1];
      flag_z <= head_zero;
    end
  end
endmodule
